// File: rtl/freq_meas_monitor.sv
// Samples the upstream freq/phase words once per measurement window, averages
// 2^AVG_LOG2 stable samples, tracks min/max and presents results on valid/ready.
module freq_meas_monitor #(
   parameter int DSIZE      = 16,
   parameter int AVG_LOG2   = 2,
   parameter int WIN_LEN    = 65536,
   parameter int SAMPLE_OFS = 32768
) (
   input  logic             clock,
   input  logic             rst,
   input  logic [DSIZE-1:0] freq_in,
   input  logic [DSIZE-1:0] phase_in,
   input  logic [DSIZE-1:0] lo_thresh,
   input  logic [DSIZE-1:0] hi_thresh,
   input  logic             out_ready,
   input  logic             clr,
   output logic             out_valid,
   output logic [DSIZE-1:0] avg_freq,
   output logic [7:0]       avg_duty,
   output logic [DSIZE-1:0] min_freq,
   output logic [DSIZE-1:0] max_freq,
   output logic             alarm_lo,
   output logic             alarm_hi,
   output logic             overrun,
   output logic             sample_miss
);

   localparam int CW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam int FW = DSIZE + AVG_LOG2;
   localparam int DW = 8 + AVG_LOG2;
   localparam int NW = AVG_LOG2 + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIN_LEN - 1);
   localparam logic [CW-1:0] CNT_OFS  = CW'(SAMPLE_OFS);
   localparam logic [NW-1:0] NUM_LAST = NW'((1 << AVG_LOG2) - 1);

   typedef enum logic {ST_WAIT = 1'b0, ST_SETTLE = 1'b1} state_t;

   state_t             state_reg, state_next;
   logic [2*DSIZE-1:0] s1_reg, s2_reg;
   logic [CW-1:0]      win_reg;
   logic [FW-1:0]      facc_reg;
   logic [DW-1:0]      dacc_reg;
   logic [NW-1:0]      num_reg;
   logic [DSIZE-1:0]   run_min_reg, run_max_reg;

   logic               stable, capture, miss, complete, load, drop;
   logic [DSIZE-1:0]   samp_freq, min_next, max_next, avg_freq_new;
   logic [7:0]         samp_duty, avg_duty_new;
   logic [FW-1:0]      facc_sum;
   logic [DW-1:0]      dacc_sum;

   // Two-stage capture; equal stages mean the upstream word was not mid-update.
   always_ff @(posedge clock) begin
      if (rst) begin
         s1_reg <= '0;
         s2_reg <= '0;
      end else begin
         s1_reg <= {freq_in, phase_in};
         s2_reg <= s1_reg;
      end
   end

   assign stable    = (s1_reg == s2_reg);
   assign samp_freq = s2_reg[2*DSIZE-1:DSIZE];
   assign samp_duty = s2_reg[DSIZE-1:DSIZE-8];

   always_ff @(posedge clock) begin
      if (rst || win_reg == CNT_LAST) begin
         win_reg <= '0;
      end else begin
         win_reg <= win_reg + CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_reg <= ST_WAIT;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_WAIT:   if (win_reg == CNT_OFS) state_next = ST_SETTLE;
         ST_SETTLE: if (stable || win_reg == CNT_LAST) state_next = ST_WAIT;
         default:   state_next = ST_WAIT;
      endcase
   end

   always_comb begin
      capture = 1'b0;
      miss    = 1'b0;
      if (state_reg == ST_SETTLE) begin
         capture = stable;
         miss    = !stable && (win_reg == CNT_LAST);
      end
   end

   assign facc_sum     = facc_reg + FW'(samp_freq);
   assign dacc_sum     = dacc_reg + DW'(samp_duty);
   assign avg_freq_new = facc_sum[FW-1:AVG_LOG2];
   assign avg_duty_new = dacc_sum[DW-1:AVG_LOG2];
   assign min_next     = (num_reg == '0 || samp_freq < run_min_reg) ? samp_freq : run_min_reg;
   assign max_next     = (num_reg == '0 || samp_freq > run_max_reg) ? samp_freq : run_max_reg;
   assign complete     = capture && (num_reg == NUM_LAST);
   assign drop         = complete && out_valid && !out_ready;
   assign load         = complete && !drop;

   always_ff @(posedge clock) begin
      if (rst) begin
         facc_reg    <= '0;
         dacc_reg    <= '0;
         num_reg     <= '0;
         run_min_reg <= '0;
         run_max_reg <= '0;
      end else if (capture) begin
         run_min_reg <= min_next;
         run_max_reg <= max_next;
         if (complete) begin
            facc_reg <= '0;
            dacc_reg <= '0;
            num_reg  <= '0;
         end else begin
            facc_reg <= facc_sum;
            dacc_reg <= dacc_sum;
            num_reg  <= num_reg + NW'(1);
         end
      end
   end

   // A dropped block still clears the accumulators; only the held result survives.
   always_ff @(posedge clock) begin
      if (rst) begin
         out_valid   <= 1'b0;
         avg_freq    <= '0;
         avg_duty    <= '0;
         min_freq    <= '0;
         max_freq    <= '0;
         alarm_lo    <= 1'b0;
         alarm_hi    <= 1'b0;
         overrun     <= 1'b0;
         sample_miss <= 1'b0;
      end else begin
         if (load) begin
            out_valid <= 1'b1;
            avg_freq  <= avg_freq_new;
            avg_duty  <= avg_duty_new;
            min_freq  <= min_next;
            max_freq  <= max_next;
            alarm_lo  <= (avg_freq_new < lo_thresh);
            alarm_hi  <= (avg_freq_new > hi_thresh);
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         overrun     <= (overrun && !clr) || drop;
         sample_miss <= (sample_miss && !clr) || miss;
      end
   end

endmodule

// File: tb/tb_freq_meas_monitor.sv
// Scoreboard bench: a window-level reference model queues expected results,
// a negedge monitor pops and compares on every accepted result.
module tb_freq_meas_monitor;

   localparam int DS  = 16;
   localparam int AL  = 2;
   localparam int NS  = 1 << AL;
   localparam int WIN = 16;
   localparam int OFS = 8;

   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] freq_in = '0, phase_in = '0;
   logic [15:0] lo_thresh = 16'd50, hi_thresh = 16'd200;
   logic        out_ready = 1'b0, clr = 1'b0;
   logic        out_valid, alarm_lo, alarm_hi, overrun, sample_miss;
   logic [15:0] avg_freq, min_freq, max_freq;
   logic [7:0]  avg_duty;

   freq_meas_monitor #(.DSIZE(DS), .AVG_LOG2(AL), .WIN_LEN(WIN), .SAMPLE_OFS(OFS)) dut (
      .clock(clock), .rst(rst), .freq_in(freq_in), .phase_in(phase_in),
      .lo_thresh(lo_thresh), .hi_thresh(hi_thresh), .out_ready(out_ready), .clr(clr),
      .out_valid(out_valid), .avg_freq(avg_freq), .avg_duty(avg_duty),
      .min_freq(min_freq), .max_freq(max_freq), .alarm_lo(alarm_lo), .alarm_hi(alarm_hi),
      .overrun(overrun), .sample_miss(sample_miss)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] af;
      logic [7:0]  ad;
      logic [15:0] mn;
      logic [15:0] mx;
      logic        lo;
      logic        hi;
   } res_t;

   int          n_cmp = 0, n_bad = 0, n_res = 0;
   bit          started = 0;
   res_t        exp_q[$];
   logic [31:0] hist[$];
   int          blk_f[$], blk_d[$];
   int          m_pos = 0;
   bit          m_got = 0, m_valid = 0, m_ov = 0, m_miss = 0, m_rst_prev = 1;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Reference: in each window the first position after SAMPLE_OFS whose two
   // preceding input cycles agree is the capture; none by window end is a miss.
   task automatic model_step();
      bit   cap = 0, mis = 0, done = 0, drop = 0;
      int   n, sf, sd, mn, mx;
      logic [31:0] sv;
      res_t r;
      if (rst) begin
         if (m_valid && !out_ready && exp_q.size() > 0) void'(exp_q.pop_back());
         blk_f.delete();
         blk_d.delete();
         m_valid = 0; m_ov = 0; m_miss = 0; m_pos = 0; m_got = 0; m_rst_prev = 1;
      end else begin
         m_rst_prev = 0;
         if (m_pos == 0) m_got = 0;
         n = hist.size();
         if (m_pos > OFS && !m_got && n >= 2) begin
            if (hist[n-1] == hist[n-2]) begin
               cap = 1; sv = hist[n-2]; m_got = 1;
            end else if (m_pos == WIN - 1) begin
               mis = 1;
            end
         end
         if (cap) begin
            blk_f.push_back(int'(sv[31:16]));
            blk_d.push_back(int'(sv[15:8]));
            if (blk_f.size() == NS) begin
               sf = 0; sd = 0; mn = blk_f[0]; mx = blk_f[0];
               foreach (blk_f[i]) begin
                  sf += blk_f[i];
                  sd += blk_d[i];
                  if (blk_f[i] < mn) mn = blk_f[i];
                  if (blk_f[i] > mx) mx = blk_f[i];
               end
               r.af = 16'(sf / NS);
               r.ad = 8'(sd / NS);
               r.mn = 16'(mn);
               r.mx = 16'(mx);
               r.lo = (r.af < lo_thresh);
               r.hi = (r.af > hi_thresh);
               blk_f.delete();
               blk_d.delete();
               done = 1;
            end
         end
         if (done) begin
            if (m_valid && !out_ready) drop = 1;
            else begin
               exp_q.push_back(r);
               m_valid = 1;
            end
         end else if (m_valid && out_ready) begin
            m_valid = 0;
         end
         m_ov   = (m_ov && !clr) || drop;
         m_miss = (m_miss && !clr) || mis;
         m_pos  = (m_pos + 1) % WIN;
      end
      hist.push_back({freq_in, phase_in});
      if (hist.size() > 4) void'(hist.pop_front());
   endtask

   task automatic cycle(input logic [15:0] f, input logic [15:0] ph,
                        input logic rdy, input logic c, input logic r);
      @(posedge clock);
      #1;
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("overrun", int'(overrun), int'(m_ov));
      chk("sample_miss", int'(sample_miss), int'(m_miss));
      if (m_rst_prev) begin
         chk("rst_avg_freq", int'(avg_freq), 0);
         chk("rst_avg_duty", int'(avg_duty), 0);
         chk("rst_min_freq", int'(min_freq), 0);
         chk("rst_max_freq", int'(max_freq), 0);
         chk("rst_alarms", int'({alarm_lo, alarm_hi}), 0);
      end
      freq_in = f; phase_in = ph; out_ready = rdy; clr = c; rst = r;
      model_step();
   endtask

   task automatic win(input logic [15:0] f, input logic [15:0] ph, input logic rdy);
      for (int p = 0; p < WIN; p++) cycle(f, ph, rdy, 1'b0, 1'b0);
   endtask

   task automatic do_rst();
      cycle(16'd0, 16'd0, 1'b1, 1'b0, 1'b1);
   endtask

   always @(negedge clock) begin
      res_t e;
      if (started && out_valid && out_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_result: got avg_freq=%0d, expected no result", avg_freq);
         end else begin
            e = exp_q.pop_front();
            n_res++;
            if ({avg_freq, avg_duty, min_freq, max_freq, alarm_lo, alarm_hi} !==
                {e.af, e.ad, e.mn, e.mx, e.lo, e.hi}) begin
               n_bad++;
               $display("FAIL result_%0d: got af=%0d ad=%0d mn=%0d mx=%0d lo=%0d hi=%0d, expected af=%0d ad=%0d mn=%0d mx=%0d lo=%0d hi=%0d",
                        n_res, avg_freq, avg_duty, min_freq, max_freq, alarm_lo, alarm_hi,
                        e.af, e.ad, e.mn, e.mx, e.lo, e.hi);
            end else begin
               $display("result %0d ok: avg_freq=%0d avg_duty=%0d min=%0d max=%0d lo=%0d hi=%0d",
                        n_res, avg_freq, avg_duty, min_freq, max_freq, alarm_lo, alarm_hi);
            end
         end
      end
   end

   initial begin
      logic [15:0] f, f2, ph;
      logic        rdy, c, r;
      cycle(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
      started = 1;

      // constant input, always ready
      do_rst();
      for (int w = 0; w < 3 * NS; w++) win(16'd100, 16'h8000, 1'b1);

      // per-window values with truncating average
      do_rst();
      win(16'd10, 16'h4000, 1'b1);
      win(16'd20, 16'h6000, 1'b1);
      win(16'd30, 16'h8000, 1'b1);
      win(16'd41, 16'hA100, 1'b1);
      win(16'd41, 16'hA100, 1'b1);

      // overrun while held, sticky clear, then accept
      do_rst();
      for (int w = 0; w < NS; w++) win(16'd70, 16'h4000, 1'b0);
      for (int w = 0; w < NS; w++) win(16'd90, 16'h2000, 1'b0);
      cycle(16'd90, 16'h2000, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(16'd90, 16'h2000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(16'd90, 16'h2000, 1'b1, 1'b0, 1'b0);

      // one window corrupted by toggling input
      do_rst();
      win(16'd5, 16'h3000, 1'b1);
      for (int p = 0; p < WIN; p++)
         cycle((p >= 8) ? ((p % 2 == 1) ? 16'd5 : 16'd6) : 16'd5, 16'h3000, 1'b1, 1'b0, 1'b0);
      for (int w = 0; w < NS; w++) win(16'd5, 16'h3000, 1'b1);

      // alarm levels
      do_rst();
      for (int w = 0; w < NS; w++) win(16'd40, 16'h1000, 1'b1);
      for (int w = 0; w < NS; w++) win(16'd250, 16'h1000, 1'b1);
      for (int w = 0; w < NS; w++) win(16'd200, 16'h1000, 1'b1);

      // reset mid-block discards the partial block
      do_rst();
      win(16'd999, 16'hFF00, 1'b1);
      win(16'd999, 16'hFF00, 1'b1);
      do_rst();
      for (int w = 0; w < NS + 1; w++) win(16'd11, 16'h2200, 1'b1);

      // randomized windows with glitches, backpressure, clears and resets
      do_rst();
      for (int w = 0; w < 60; w++) begin
         f  = 16'($urandom_range(0, 300));
         ph = 16'($urandom);
         for (int p = 0; p < WIN; p++) begin
            f2  = (p >= 7 && $urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 300)) : f;
            rdy = ($urandom_range(0, 3) != 0);
            c   = ($urandom_range(0, 15) == 0);
            r   = ($urandom_range(0, 299) == 0);
            cycle(f2, ph, rdy, c, r);
         end
      end

      // drain: inputs never stable, consumer always ready
      for (int i = 0; i < 20; i++) cycle(16'(i * 7 + 1), 16'(i), 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      #1;
      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
